// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-producer accepted-word counters are built when ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            fifo_wen,
  output logic [DATA_WIDTH-1:0]           fifo_wdata,
  input  logic                            fifo_full,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    stat_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_grant;
  logic [BW-1:0] beat_cnt;
  logic [IW-1:0] next_idx;
  logic          any_req;
  logic          req_g;
  logic          accept;

  // Search upward from last_grant+1, wrapping; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    next_idx = last_grant;
    any_req  = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req  = 1'b1;
        next_idx = IW'(cand);
      end
    end
  end

  // A word presented during reset is never acked, so an aborted burst writes nothing extra.
  assign req_g  = req[grant_q];
  assign accept = (state == ST_BURST) && req_g && !fifo_full && !rst;

  always_comb begin
    ack          = '0;
    ack[grant_q] = accept;
  end

  assign fifo_wen    = accept;
  assign fifo_wdata  = req_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_valid = (state == ST_BURST);
  assign grant_idx   = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q  <= next_idx;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BW'(MAX_BURST - 1)) begin
              state      <= ST_IDLE;
              last_grant <= grant_q;
            end
          end else if (!req_g) begin
            state      <= ST_IDLE;
            last_grant <= grant_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected FIFO writes, a negedge monitor pops them.
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]   ack;
  logic         fifo_wen;
  logic [31:0]  fifo_wdata;
  logic         fifo_full = 1'b0;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [15:0]  stat_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_wdata(req_wdata), .ack(ack),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .stat_cnt(stat_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   glog[$];

  logic [31:0] pdata [4][64];
  int          pcnt  [4];
  int          phead [4];
  logic [3:0]  ack_seen = '0;
  bit          prev_gv = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          total_acks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    ack_seen = ack;
    if (grant_valid === 1'b1 && !prev_gv) glog.push_back(int'(grant_idx));
    prev_gv = (grant_valid === 1'b1);
    if (fifo_wen === 1'b1) begin
      total_acks++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_write: got data %0h expected no write", fifo_wdata);
      end else begin
        e = sb.pop_front();
        chk("mon_wdata", fifo_wdata, e.data);
        chk("mon_ack", ack, 64'(4'b0001 << e.idx));
      end
    end else begin
      chk("mon_idle_ack", ack, 0);
    end
  end

  task automatic apply_inputs();
    for (int i = 0; i < 4; i++) begin
      req[i] = (phead[i] < pcnt[i]);
      req_wdata[i*32 +: 32] = req[i] ? pdata[i][phead[i]] : 32'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (ack_seen[i]) phead[i]++;
    apply_inputs();
    #1;
  endtask

  task automatic add(input int p, input logic [31:0] d, input bit push_exp);
    exp_t e;
    pdata[p][pcnt[p]] = d;
    pcnt[p]++;
    if (push_exp) begin
      e.idx = p;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic expect_word(input int p, input logic [31:0] d);
    exp_t e;
    e.idx = p;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin pcnt[i] = 0; phead[i] = 0; end
    apply_inputs();
    step();
    step();
    rst = 1'b0;
    glog.delete();
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin step(); n++; end
    chk({name, "_drain"}, sb.size(), 0);
    step();
    step();
    chk({name, "_idle_gv"}, grant_valid, 0);
    chk({name, "_idle_wen"}, fifo_wen, 0);
  endtask

  initial begin
    int n;
    int a0;
    do_reset();
    chk("rst_gv", grant_valid, 0);
    chk("rst_gidx", grant_idx, 0);
    chk("rst_ack", ack, 0);
    chk("rst_wen", fifo_wen, 0);

    // Test 1: single producer 2, three words then drop.
    for (int k = 0; k < 3; k++) add(2, 32'hA0 + k, 1'b1);
    apply_inputs();
    #1;
    chk("t1_arb_no_wen", fifo_wen, 0);
    step();
    chk("t1_gv", grant_valid, 1);
    chk("t1_gidx", grant_idx, 2);
    for (int k = 0; k < 3; k++) begin
      chk("t1_wen", fifo_wen, 1);
      chk("t1_ack", ack, 4'b0100);
      step();
    end
    chk("t1_after_wen", fifo_wen, 0);
    step();
    chk("t1_back_idle", grant_valid, 0);
    drain("t1");

    // Test 2: all four requesting, 36-cycle throughput window.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < 8; k++) begin
          add(p, 32'h1000 * (p + 1) + r * 8 + k, 1'b0);
          expect_word(p, 32'h1000 * (p + 1) + r * 8 + k);
        end
    apply_inputs();
    #1;
    a0 = total_acks;
    for (int c = 0; c < 36; c++) step();
    chk("t2_words_in_36", total_acks - a0, 32);
    drain("t2");
    chk("t2_ngrants", glog.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      if (k < glog.size()) chk("t2_grant_seq", glog[k], k % 4);

    // Test 3: producer 1 stalled by fifo_full after 3 beats.
    do_reset();
    for (int k = 0; k < 8; k++) add(1, 32'h30 + k, 1'b1);
    apply_inputs();
    n = 0;
    while (phead[1] < 3 && n < 50) begin step(); n++; end
    chk("t3_three_beats", phead[1], 3);
    fifo_full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t3_full_wen", fifo_wen, 0);
      chk("t3_full_ack", ack, 0);
      chk("t3_full_gidx", grant_idx, 1);
      chk("t3_full_gv", grant_valid, 1);
      step();
    end
    chk("t3_held_beats", phead[1], 3);
    fifo_full = 1'b0;
    #1;
    drain("t3");
    chk("t3_total", phead[1], 8);
    chk("t3_one_grant", glog.size(), 1);

    // Test 4: producer 0 drops after 2 words; 1 follows; 0 returns after 1's burst.
    do_reset();
    add(0, 32'h40, 1'b1);
    add(0, 32'h41, 1'b1);
    for (int k = 0; k < 8; k++) add(1, 32'h50 + k, 1'b1);
    apply_inputs();
    n = 0;
    while (!(grant_valid === 1'b1 && grant_idx == 2'd1) && n < 50) begin step(); n++; end
    chk("t4_grant1_seen", grant_idx, 1);
    add(0, 32'h42, 1'b1);
    add(0, 32'h43, 1'b1);
    apply_inputs();
    drain("t4");
    chk("t4_ngrants", glog.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < glog.size()) chk("t4_grant_seq", glog[k], (k == 1) ? 1 : 0);

    // Test 5: reset in the middle of producer 3's burst.
    do_reset();
    for (int k = 0; k < 8; k++) add(3, 32'h70 + k, 1'b0);
    for (int k = 0; k < 4; k++) expect_word(3, 32'h70 + k);
    apply_inputs();
    n = 0;
    while (phead[3] < 4 && n < 50) begin step(); n++; end
    chk("t5_four_beats", phead[3], 4);
    rst = 1'b1;
    #1;
    chk("t5_rst_wen", fifo_wen, 0);
    chk("t5_rst_ack", ack, 0);
    add(0, 32'h60, 1'b1);
    add(0, 32'h61, 1'b1);
    for (int k = 4; k < 8; k++) expect_word(3, 32'h70 + k);
    step();
    rst = 1'b0;
    #1;
    chk("t5_post_gv", grant_valid, 0);
    chk("t5_post_ack", ack, 0);
    chk("t5_post_wen", fifo_wen, 0);
    step();
    chk("t5_regrant_gv", grant_valid, 1);
    chk("t5_regrant_idx", grant_idx, 0);
    drain("t5");

    // Test 6: producer 2 sends 20 words; counters saturate when built.
    do_reset();
    for (int k = 0; k < 20; k++) add(2, 32'h200 + k, 1'b1);
    apply_inputs();
    drain("t6");
`ifdef ARB_STATS_EN
    chk("t6_stat2_sat", stat_cnt[8 +: 4], 15);
    chk("t6_stat0", stat_cnt[0 +: 4], 0);
    chk("t6_stat1", stat_cnt[4 +: 4], 0);
    chk("t6_stat3", stat_cnt[12 +: 4], 0);
    do_reset();
    chk("t6_stat_rst", stat_cnt, 0);
`else
    chk("t6_stat_tied", stat_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one FIFO write port between NUM_REQ independent producers.
- Grants one producer at a time for a burst of up to MAX_BURST words, then rotates. Honours the FIFO full flag with zero-latency backpressure.
- Sits directly in front of the fifo slave write interface (wen/wdata/full); the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 32, word width, matches FIFO wdata.
- MAX_BURST, 8, maximum words accepted per grant (1..256).
- CNT_WIDTH, 16, width of each per-producer statistics counter (used only with ARB_STATS_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request; bit i high = producer i has a word on its wdata slice.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened producer data; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot or zero; bit i high = producer i's word accepted this cycle.
- fifo_wen  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- grant_valid  out  1  a burst grant is active.
- grant_idx  out  $clog2(NUM_REQ)  index of the granted producer; valid when grant_valid=1.
- stat_cnt  out  NUM_REQ*CNT_WIDTH  per-producer accepted-word counters (ARB_STATS_EN only).

Behaviour:
- State machine with 2 states, IDLE and BURST.
- Reset:
  - State goes to IDLE; grant_valid=0; grant_idx=0; beat_cnt=0.
  - last_grant=NUM_REQ-1, so producer 0 wins first.
  - ack=0, fifo_wen=0.
  - A reset asserted mid-burst aborts the burst at that edge; any word not yet acked is not written.
- IDLE:
  - If any req bit is high, pick the first set bit searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - Register it into grant_idx, set grant_valid=1, clear beat_cnt, go to BURST.
  - No word is accepted in IDLE, so there is exactly one arbitration cycle per burst.
- BURST:
  - accept = req[grant_idx] & ~fifo_full.
  - ack[grant_idx]=accept and fifo_wen=accept, both combinational in the same cycle.
  - fifo_wdata = req_wdata slice grant_idx, driven regardless of accept.
  - On accept, beat_cnt increments.
- Burst exit to IDLE (grant_valid=0, last_grant<=grant_idx) occurs when either:
  - accept occurs with beat_cnt==MAX_BURST-1, or
  - req[grant_idx]==0. No word is accepted in that cycle.
- fifo_full during BURST:
  - Grant is held; ack and wen stay low; beat_cnt holds.
  - The burst resumes when full clears. No timeout.
- Outputs when idle:
  - ack bits other than grant_idx are always 0.
  - ack=0 and fifo_wen=0 whenever grant_valid=0.
- Producer contract:
  - Hold req and data stable until acked.
  - Deasserting req without ack is permitted and ends the burst.
- Words from one producer reach the FIFO in ack order. There is no interleaving within a burst.
- Steady-state throughput with all producers requesting is MAX_BURST words per MAX_BURST+1 cycles.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - stat_cnt slice i increments on every ack[i].
  - Each counter saturates at 2^CNT_WIDTH-1 and never wraps.
  - Counters clear to 0 on rst.
- Undefined:
  - No counter logic is built; stat_cnt is tied to 0.

Test Plan:
1. Reset, then req=4'b0100 held with data 0xA0, 0xA1, 0xA2, dropped after the third ack.
   - Expected: grant_idx=2 one cycle after req is seen; ack[2] and fifo_wen high for 3 consecutive cycles; FIFO receives 0xA0, 0xA1, 0xA2; returns to IDLE.
2. req=4'b1111 held continuously, fifo_full=0.
   - Expected: grant sequence 0,1,2,3,0; each burst exactly 8 acks; one idle cycle between bursts; 32 words in 36 cycles.
3. Single producer 1 bursting; fifo_full forced high after beat 3 for 5 cycles.
   - Expected: ack and wen low for those 5 cycles; grant_idx stays 1; 5 more words follow once full clears, 8 total.
4. req=4'b0011; producer 0 drops req after 2 acks.
   - Expected: burst ends with 2 words; next grant is 1; a subsequent grant returns to 0 only after 1's burst.
5. rst asserted for 1 cycle at beat 4 of producer 3's burst.
   - Expected: next cycle grant_valid=0, ack=0, wen=0; with req=4'b1001 the next grant is 0.
6. ARB_STATS_EN defined, CNT_WIDTH=4, producer 2 sends 20 words.
   - Expected: stat_cnt slice 2 reads 15 (saturated); other slices read 0; rst returns all slices to 0.
